// File: rtl/editor_pkg.sv
// Shared definitions for the parameter editor.
//   - field index constants and the MIN / MAX / RESET limit tables
//   - repeat FSM state type
//   - days_in_month() and field_max() helpers used for day wrapping/clamping
package editor_pkg;

    localparam int N_MAX = 9;

    localparam int F_YEAR  = 0;
    localparam int F_MONTH = 1;
    localparam int F_DAY   = 2;
    localparam int F_HOUR  = 3;
    localparam int F_MIN   = 4;
    localparam int F_SEC   = 5;
    localparam int F_THOUR = 6;
    localparam int F_TMIN  = 7;
    localparam int F_TSEC  = 8;

    typedef logic [6:0] campo_t;

    localparam campo_t LIM_MIN [N_MAX] = '{7'd0, 7'd1, 7'd1, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0};
    // Day max entry is the longest month; the per-month bound comes from days_in_month().
    localparam campo_t LIM_MAX [N_MAX] = '{7'd99, 7'd12, 7'd31, 7'd23, 7'd59, 7'd59, 7'd23, 7'd59, 7'd59};
    localparam campo_t LIM_RST [N_MAX] = '{7'd0, 7'd1, 7'd1, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } rep_state_t;

    // Leap rule is year mod 4 == 0 (two-digit year, 2000..2099).
    function automatic campo_t days_in_month(input campo_t mes, input campo_t anio);
        case (mes)
            7'd2:                      return (anio[1:0] == 2'b00) ? 7'd29 : 7'd28;
            7'd4, 7'd6, 7'd9, 7'd11:   return 7'd30;
            default:                   return 7'd31;
        endcase
    endfunction

    function automatic campo_t field_max(input int idx, input campo_t mes, input campo_t anio);
        if (idx == F_DAY)
            return days_in_month(mes, anio);
        return LIM_MAX[idx];
    endfunction

endpackage

// File: rtl/bin2bcd_8.sv
// Binary to two-digit packed BCD for one field value.
//   bin : binary value, 0..99
//   bcd : {tens, units} BCD digits
module bin2bcd_8 (
    input  logic [7:0] bin,
    output logic [7:0] bcd
);

    logic [3:0] decenas;
    logic [3:0] unidades;

    always_comb begin
        decenas  = 4'(bin / 8'd10);
        unidades = 4'(bin - 8'(decenas) * 8'd10);
        bcd      = {decenas, unidades};
    end

endmodule

// File: rtl/editor_parametros.sv
// Editable field bank (date, time, timer) with up/down keys and auto-repeat.
//   clk     : system clock, rising edge
//   rst     : asynchronous reset, active low
//   sel     : one-hot field select (N_CAMPOS bits)
//   up/down : level key requests, already synchronous and debounced
//   forma   : hour display mode, 0 = 24 h, 1 = 12 h
//   valores : registered packed BCD, field i at [8i+7:8i]
//   pm      : registered 12 h afternoon flag for the hour field
//
// Repeat FSM:
//   state     | meaning
//   ST_IDLE   | no key held; a clean rising edge steps once and enters HOLD
//   ST_HOLD   | key held, waiting REP_DELAY cycles before auto-repeat
//   ST_REPEAT | key still held, one step every REP_RATE cycles
module editor_parametros
    import editor_pkg::*;
#(
    parameter int N_CAMPOS  = 9,
    parameter int REP_DELAY = 50_000_000,
    parameter int REP_RATE  = 10_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CAMPOS-1:0]   sel,
    input  logic                  up,
    input  logic                  down,
    input  logic                  forma,
    output logic [8*N_CAMPOS-1:0] valores,
    output logic                  pm
);

    localparam int CW = (REP_DELAY > 2) ? $clog2(REP_DELAY) : 1;
    localparam logic [CW-1:0] FIN_HOLD = CW'(REP_DELAY - 1);
    localparam logic [CW-1:0] FIN_REP  = CW'(REP_RATE - 1);

    rep_state_t            estado_q, estado_d;
    logic [CW-1:0]         cnt_q;
    logic                  up_q, down_q;
    logic [N_CAMPOS-1:0]   sel_q;
    logic                  bloqueo_q;
    logic                  dir_q;

    logic                  sel_valido, sel_cambio;
    logic                  sube, baja, arranque, tecla_suelta, aborta;
    logic                  paso, paso_dir, cnt_clr;

    campo_t                campo_q [N_MAX];
    campo_t                campo_d [N_MAX];
    logic [N_MAX-1:0]      sel_ext;
    campo_t                dia_max;
    campo_t                hora12;
    logic [7:0]            bin_vis [N_MAX];
    logic [7:0]            bcd_w   [N_CAMPOS];
    logic                  pm_d;

    // Key conditioning
    always_comb begin
        sel_valido   = $onehot(sel);
        sel_cambio   = (sel != sel_q);
        sube         = up & ~up_q;
        baja         = down & ~down_q;
        // bloqueo_q keeps a key that was already down across reset from stepping.
        arranque     = sel_valido & ~bloqueo_q & ((sube & ~down) | (baja & ~up));
        tecla_suelta = dir_q ? ~up : ~down;
        aborta       = ~sel_valido | sel_cambio | (up & down) | tecla_suelta;
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            estado_q <= ST_IDLE;
        else
            estado_q <= estado_d;
    end

    // FSM: next state
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            ST_IDLE: begin
                if (arranque)
                    estado_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (aborta)
                    estado_d = ST_IDLE;
                else if (cnt_q == FIN_HOLD)
                    estado_d = ST_REPEAT;
            end
            ST_REPEAT: begin
                if (aborta)
                    estado_d = ST_IDLE;
            end
            default: estado_d = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        paso     = 1'b0;
        paso_dir = dir_q;
        cnt_clr  = 1'b1;
        case (estado_q)
            ST_IDLE: begin
                paso     = arranque;
                paso_dir = sube;
            end
            ST_HOLD: begin
                cnt_clr = aborta | (cnt_q == FIN_HOLD);
                paso    = ~aborta & (cnt_q == FIN_HOLD);
            end
            ST_REPEAT: begin
                cnt_clr = aborta | (cnt_q == FIN_REP);
                paso    = ~aborta & (cnt_q == FIN_REP);
            end
            default: begin
                paso    = 1'b0;
                cnt_clr = 1'b1;
            end
        endcase
    end

    // Counter, edge samples and held-key direction
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            up_q      <= 1'b0;
            down_q    <= 1'b0;
            sel_q     <= '0;
            bloqueo_q <= 1'b1;
            dir_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_clr ? '0 : cnt_q + 1'b1;
            up_q      <= up;
            down_q    <= down;
            sel_q     <= sel;
            bloqueo_q <= bloqueo_q & (up | down);
            if (estado_q == ST_IDLE && arranque)
                dir_q <= sube;
        end
    end

    // Field update: step with wrap, plus day clamp after month/year changes
    always_comb begin
        sel_ext = N_MAX'(sel);
        dia_max = days_in_month(campo_q[F_MONTH], campo_q[F_YEAR]);
        for (int i = 0; i < N_MAX; i++) begin
            campo_d[i] = campo_q[i];
            if (i < N_CAMPOS && paso && sel_ext[i]) begin
                if (paso_dir)
                    campo_d[i] = (campo_q[i] >= field_max(i, campo_q[F_MONTH], campo_q[F_YEAR]))
                                 ? LIM_MIN[i] : campo_q[i] + 7'd1;
                else
                    campo_d[i] = (campo_q[i] <= LIM_MIN[i])
                                 ? field_max(i, campo_q[F_MONTH], campo_q[F_YEAR]) : campo_q[i] - 7'd1;
            end else if (i == F_DAY && campo_q[i] > dia_max) begin
                campo_d[i] = dia_max;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_MAX; i++)
                campo_q[i] <= LIM_RST[i];
        end else begin
            for (int i = 0; i < N_MAX; i++)
                campo_q[i] <= campo_d[i];
        end
    end

    // Display path: 12 h remap of the hour slot only, stored hour untouched
    always_comb begin
        hora12 = campo_q[F_HOUR];
        if (campo_q[F_HOUR] == 7'd0)
            hora12 = 7'd12;
        else if (campo_q[F_HOUR] > 7'd12)
            hora12 = campo_q[F_HOUR] - 7'd12;

        for (int i = 0; i < N_MAX; i++)
            bin_vis[i] = {1'b0, campo_q[i]};
        if (forma)
            bin_vis[F_HOUR] = {1'b0, hora12};

        pm_d = forma & (campo_q[F_HOUR] >= 7'd12);
    end

    for (genvar g = 0; g < N_CAMPOS; g++) begin : g_bcd
        bin2bcd_8 u_bcd (
            .bin (bin_vis[g]),
            .bcd (bcd_w[g])
        );
    end

    // All reset values are below 10, so binary equals BCD here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_CAMPOS; i++)
                valores[8*i +: 8] <= {1'b0, LIM_RST[i]};
            pm <= 1'b0;
        end else begin
            for (int i = 0; i < N_CAMPOS; i++)
                valores[8*i +: 8] <= bcd_w[i];
            pm <= pm_d;
        end
    end

endmodule
